mem_responder: RTL and testbench

//   Memory-side responder for the 5-stage core's request/grant memory interface.

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Purpose : Single-outstanding memory responder for the IF/LSU request/grant
//           interface. LSU has fixed priority, and each response arrives a
//           fixed LATENCY+1 cycles after its grant.
// Option  : MEM_RESP_REGION_CHECK_EN adds the if_err_op and lsu_err_op
//           region-check outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
   parameter int DEPTH     = 1024,
   parameter int LATENCY   = 2,
   parameter int DATA_BASE = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_en,
   input  logic        if_req_ip,
   input  logic [31:0] if_addr_ip,
   output logic        if_gnt_op,
   output logic        if_rvalid_op,
   output logic [31:0] if_rdata_op,
   input  logic        lsu_req_ip,
   input  logic        lsu_we_ip,
   input  logic [3:0]  lsu_be_ip,
   input  logic [31:0] lsu_addr_ip,
   input  logic [31:0] lsu_wdata_ip,
   output logic        lsu_gnt_op,
   output logic        lsu_rvalid_op,
   output logic [31:0] lsu_rdata_op,
   output logic        busy_op
`ifdef MEM_RESP_REGION_CHECK_EN
   ,
   output logic        if_err_op,
   output logic        lsu_err_op
`endif
);

   localparam int             c_aw        = $clog2(DEPTH);
   localparam logic [1:0]     c_idle      = 2'd0;
   localparam logic [1:0]     c_wait      = 2'd1;
   localparam logic [1:0]     c_resp      = 2'd2;
   localparam logic [3:0]     c_last      = 4'(LATENCY - 1);
   localparam logic [c_aw-1:0] c_data_base = c_aw'(DATA_BASE);

   logic [1:0]      r_state;
   logic [3:0]      r_cnt;
   logic            r_sel_lsu;
   logic            r_we;
   logic            r_err;
   logic [3:0]      r_be;
   logic [c_aw-1:0] r_idx;
   logic [31:0]     r_wdata;
   logic [31:0]     r_mem [DEPTH];

   logic            w_idle;
   logic            w_resp;
   logic            w_grant_ok;
   logic            w_gnt_lsu;
   logic            w_gnt_if;
   logic            w_if_bad;
   logic            w_lsu_bad;
   logic            w_wr;
   logic [31:0]     w_rdata;
   logic [c_aw-1:0] w_if_idx;
   logic [c_aw-1:0] w_lsu_idx;
   logic            w_unused_bits;

   assign w_idle    = (r_state == c_idle);
   assign w_resp    = (r_state == c_resp);
   assign w_if_idx  = if_addr_ip[c_aw+1:2];
   assign w_lsu_idx = lsu_addr_ip[c_aw+1:2];

   // Gating with reset keeps the combinational grants quiet while in reset.
   assign w_grant_ok = w_idle & mem_en & reset;
   assign w_gnt_lsu  = w_grant_ok & lsu_req_ip;
   assign w_gnt_if   = w_grant_ok & if_req_ip & ~lsu_req_ip;

`ifdef MEM_RESP_REGION_CHECK_EN
   assign w_if_bad  = (w_if_idx >= c_data_base);
   assign w_lsu_bad = (w_lsu_idx < c_data_base);
`else
   assign w_if_bad  = 1'b0;
   assign w_lsu_bad = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= c_idle;
         r_cnt     <= 4'd0;
         r_sel_lsu <= 1'b0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_be      <= 4'd0;
         r_idx     <= '0;
         r_wdata   <= 32'd0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_gnt_lsu || w_gnt_if) begin
                  r_state   <= c_wait;
                  r_cnt     <= 4'd0;
                  r_sel_lsu <= w_gnt_lsu;
                  r_we      <= w_gnt_lsu & lsu_we_ip;
                  r_be      <= lsu_be_ip;
                  r_wdata   <= lsu_wdata_ip;
                  r_idx     <= w_gnt_lsu ? w_lsu_idx : w_if_idx;
                  r_err     <= w_gnt_lsu ? w_lsu_bad : w_if_bad;
               end
            end
            c_wait: begin
               if (r_cnt == c_last) begin
                  r_state <= c_resp;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            c_resp:  r_state <= c_idle;
            default: r_state <= c_idle;
         endcase
      end
   end

   // Backing store is never cleared; a reset during RESP forces IDLE so no write occurs.
   assign w_wr = w_resp & r_sel_lsu & r_we & ~r_err;

   always_ff @(posedge clock) begin
      if (w_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign w_rdata = (w_resp && !r_we && !r_err) ? r_mem[r_idx] : 32'd0;

   assign if_gnt_op     = w_gnt_if;
   assign lsu_gnt_op    = w_gnt_lsu;
   assign if_rvalid_op  = w_resp & ~r_sel_lsu;
   assign lsu_rvalid_op = w_resp & r_sel_lsu;
   assign if_rdata_op   = r_sel_lsu ? 32'd0 : w_rdata;
   assign lsu_rdata_op  = r_sel_lsu ? w_rdata : 32'd0;
   assign busy_op       = ~w_idle;

`ifdef MEM_RESP_REGION_CHECK_EN
   assign if_err_op  = if_rvalid_op & r_err;
   assign lsu_err_op = lsu_rvalid_op & r_err;
`endif

   assign w_unused_bits = ^{if_addr_ip[31:c_aw+2], if_addr_ip[1:0],
                            lsu_addr_ip[31:c_aw+2], lsu_addr_ip[1:0], c_data_base};

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module  : tb_mem_responder
// Purpose : Self-checking bench for mem_responder using directed steps, random
//           traffic and a word-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

   localparam int DEPTH     = 1024;
   localparam int LATENCY   = 2;
   localparam int DATA_BASE = 128;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_en = 1'b0;
   logic        if_req_ip = 1'b0;
   logic [31:0] if_addr_ip = 32'd0;
   logic        if_gnt_op, if_rvalid_op;
   logic [31:0] if_rdata_op;
   logic        lsu_req_ip = 1'b0;
   logic        lsu_we_ip = 1'b0;
   logic [3:0]  lsu_be_ip = 4'd0;
   logic [31:0] lsu_addr_ip = 32'd0;
   logic [31:0] lsu_wdata_ip = 32'd0;
   logic        lsu_gnt_op, lsu_rvalid_op;
   logic [31:0] lsu_rdata_op;
   logic        busy_op;
`ifdef MEM_RESP_REGION_CHECK_EN
   logic        if_err_op, lsu_err_op;
`endif

   mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .DATA_BASE(DATA_BASE)) dut (
      .clock(clock), .reset(reset), .mem_en(mem_en),
      .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_gnt_op(if_gnt_op),
      .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op),
      .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_be_ip(lsu_be_ip),
      .lsu_addr_ip(lsu_addr_ip), .lsu_wdata_ip(lsu_wdata_ip), .lsu_gnt_op(lsu_gnt_op),
      .lsu_rvalid_op(lsu_rvalid_op), .lsu_rdata_op(lsu_rdata_op), .busy_op(busy_op)
`ifdef MEM_RESP_REGION_CHECK_EN
      , .if_err_op(if_err_op), .lsu_err_op(lsu_err_op)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   logic [31:0] mdl [int];   // words whose contents the bench knows

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit region_err(input bit is_lsu, input int idx);
`ifdef MEM_RESP_REGION_CHECK_EN
      return is_lsu ? (idx < DATA_BASE) : (idx >= DATA_BASE);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] mkaddr(input int idx);
      logic [31:0] hi;
      hi = $urandom() & ~32'(DEPTH * 4 - 1);
      return hi | 32'(idx * 4) | ($urandom() & 32'd3);
   endfunction

   // Compares a response against the model; unknown words are only checked on error.
   task automatic check_resp(input string tag, input bit is_lsu, input bit we, input logic [3:0] be,
                             input int idx, input logic [31:0] wdata, input logic [31:0] obs,
                             input bit obs_err);
      bit err;
      logic [31:0] nv;
      err = region_err(is_lsu, idx);
      if (we) begin
         check({tag, "_ackdata"}, obs, 0);
         if (!err) begin
            if (mdl.exists(idx) || be == 4'hf) begin
               nv = mdl.exists(idx) ? mdl[idx] : 32'd0;
               for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wdata[8*b +: 8];
               mdl[idx] = nv;
            end
         end
      end else if (err) begin
         check({tag, "_errdata"}, obs, 0);
      end else if (mdl.exists(idx)) begin
         check({tag, "_rdata"}, obs, mdl[idx]);
      end
`ifdef MEM_RESP_REGION_CHECK_EN
      check({tag, "_err"}, obs_err, err);
`else
      if (obs_err) check({tag, "_err"}, obs_err, 0);
`endif
   endtask

   // Entered and left in the drive window just after a rising edge.
   task automatic xact(input string tag, input bit is_lsu, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit drop_en);
      int gcyc, waited, idx;
      bit seen, xrv, e;
      logic [31:0] rd;
      idx = int'((addr >> 2) % DEPTH);
      if (is_lsu) begin
         lsu_req_ip = 1; lsu_we_ip = we; lsu_be_ip = be; lsu_addr_ip = addr; lsu_wdata_ip = wdata;
      end else begin
         if_req_ip = 1; if_addr_ip = addr;
      end
      seen = 0; gcyc = 0; waited = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (is_lsu ? lsu_gnt_op : if_gnt_op) begin
            seen = 1; gcyc = cyc; waited = i;
            check({tag, "_xgnt"}, is_lsu ? if_gnt_op : lsu_gnt_op, 0);
            break;
         end
         @(posedge clock); #1;
      end
      check({tag, "_gnt"}, seen, 1);
      check({tag, "_gntwait"}, waited, 0);
      @(posedge clock); #1;
      lsu_req_ip = 0; if_req_ip = 0;
      lsu_addr_ip = $urandom(); lsu_wdata_ip = $urandom(); lsu_be_ip = 4'($urandom());
      lsu_we_ip = 1'($urandom()); if_addr_ip = $urandom();
      if (drop_en) mem_en = 0;
      if (!seen) return;
      seen = 0; xrv = 0; rd = 0; e = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (is_lsu ? if_rvalid_op : lsu_rvalid_op) xrv = 1;
         if (is_lsu ? lsu_rvalid_op : if_rvalid_op) begin
            seen = 1;
            rd = is_lsu ? lsu_rdata_op : if_rdata_op;
`ifdef MEM_RESP_REGION_CHECK_EN
            e = is_lsu ? lsu_err_op : if_err_op;
`endif
            check({tag, "_lat"}, cyc - gcyc, LATENCY + 1);
            check({tag, "_busy"}, busy_op, 1);
            break;
         end
         @(posedge clock); #1;
      end
      check({tag, "_rvalid"}, seen, 1);
      check({tag, "_xrvalid"}, xrv, 0);
      if (seen) check_resp(tag, is_lsu, we, be, idx, wdata, rd, e);
      @(posedge clock); #1;
      mem_en = 1;
   endtask

   initial begin
      int pool [8] = '{3, 10, 200, 127, 128, 129, 1023, 500};
      int g1, g2;
      bit seen, xif, lsu_seen;

      // In reset: grants stay low even with requests present.
      mem_en = 1; if_req_ip = 1; lsu_req_ip = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_gnt", {if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op, busy_op}, 0);
      end
      @(posedge clock); #1;
      if_req_ip = 0; lsu_req_ip = 0; reset = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("idle_outs", {if_gnt_op, if_rvalid_op, if_rdata_op, lsu_gnt_op,
                             lsu_rvalid_op, lsu_rdata_op, busy_op}, 0);
      end
      @(posedge clock); #1;

      // Preloads, then the fetch from byte address 0x0C.
      xact("pre3", 1, 1, 4'hf, 32'h0000_000C, 32'hDEAD_BEEF, 0);
      xact("pre200", 1, 1, 4'hf, mkaddr(200), 32'hAABB_CCDD, 0);
      xact("fetch3", 0, 0, 4'h0, 32'h0000_000C, 32'd0, 0);

      // Partial store then load of word 200.
      xact("st200", 1, 1, 4'b0101, mkaddr(200), 32'h1122_3344, 0);
      xact("ld200", 1, 0, 4'h0, mkaddr(200), 32'd0, 0);
`ifndef MEM_RESP_REGION_CHECK_EN
      check("ld200_spec", mdl[200], 32'hAA22_CC44);
`endif
      xact("st_be0", 1, 1, 4'b0000, mkaddr(200), 32'hFFFF_FFFF, 0);
      xact("ld_be0", 1, 0, 4'h0, mkaddr(200), 32'd0, 0);

      // Simultaneous requests: LSU first, fetch exactly LATENCY+2 cycles later.
      lsu_req_ip = 1; lsu_we_ip = 0; lsu_addr_ip = mkaddr(200);
      if_req_ip = 1; if_addr_ip = mkaddr(3);
      @(negedge clock);
      check("arb_lsu_gnt", {lsu_gnt_op, if_gnt_op}, 2'b10);
      g1 = cyc; g2 = 0; seen = 0; xif = 0; lsu_seen = 0;
      @(posedge clock); #1;
      lsu_req_ip = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (if_rvalid_op) xif = 1;
         if (lsu_rvalid_op) begin
            lsu_seen = 1;
            check_resp("arb_lsu", 1, 0, 4'h0, 200, 32'd0, lsu_rdata_op,
`ifdef MEM_RESP_REGION_CHECK_EN
                       lsu_err_op);
`else
                       1'b0);
`endif
         end
         if (if_gnt_op) begin seen = 1; g2 = cyc; break; end
         @(posedge clock); #1;
      end
      check("arb_if_gnt", seen, 1);
      check("arb_spacing", g2 - g1, LATENCY + 2);
      check("arb_lsu_rvalid", lsu_seen, 1);
      check("arb_no_if_rvalid", xif, 0);
      @(posedge clock); #1;
      if_req_ip = 0; seen = 0; xif = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (lsu_rvalid_op) xif = 1;
         if (if_rvalid_op) begin
            seen = 1;
            check("arb_if_lat", cyc - g2, LATENCY + 1);
            check_resp("arb_if", 0, 0, 4'h0, 3, 32'd0, if_rdata_op,
`ifdef MEM_RESP_REGION_CHECK_EN
                       if_err_op);
`else
                       1'b0);
`endif
            break;
         end
         @(posedge clock); #1;
      end
      check("arb_if_rvalid", seen, 1);
      check("arb_no_lsu_rvalid", xif, 0);
      @(posedge clock); #1;

      // mem_en low blocks new grants; falling mid-flight still completes.
      mem_en = 0; lsu_req_ip = 1; lsu_we_ip = 0; lsu_addr_ip = mkaddr(200);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("en_off_gnt", {lsu_gnt_op, busy_op}, 0);
         @(posedge clock); #1;
      end
      mem_en = 1;
      xact("en_on", 1, 0, 4'h0, mkaddr(200), 32'd0, 0);
      xact("en_drop", 0, 0, 4'h0, mkaddr(3), 32'd0, 1);

      // Reset one cycle after a store grant aborts it.
      lsu_req_ip = 1; lsu_we_ip = 1; lsu_be_ip = 4'hf; lsu_addr_ip = mkaddr(200);
      lsu_wdata_ip = 32'h5A5A_5A5A;
      @(negedge clock);
      check("abort_gnt", lsu_gnt_op, 1);
      @(posedge clock); #1;
      lsu_req_ip = 0; reset = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("abort_quiet", {lsu_rvalid_op, if_rvalid_op, busy_op}, 0);
      end
      @(posedge clock); #1;
      reset = 1;
      @(negedge clock);
      check("abort_idle", busy_op, 0);
      @(posedge clock); #1;
      xact("abort_ld", 1, 0, 4'h0, mkaddr(200), 32'd0, 0);

      // Store into the instruction region.
      xact("st10", 1, 1, 4'hf, mkaddr(10), 32'hC0FF_EE10, 0);
      xact("ld10", 1, 0, 4'h0, mkaddr(10), 32'd0, 0);

      // Random traffic over a small pool of words.
      foreach (pool[k]) xact("rnd_pre", 1, 1, 4'hf, mkaddr(pool[k]), $urandom(), 0);
      for (int n = 0; n < 40; n++) begin
         bit l;
         l = 1'($urandom());
         xact("rnd", l, l & 1'($urandom()), 4'($urandom()), mkaddr(pool[$urandom_range(0, 7)]),
              $urandom(), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL timeout: observed no finish, expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
